// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: PCSrc codes,
// operand forward selects and the mul/div sequencing FSM state type.
package hazard_pkg;

  // PCSrc decode from ID: 000 sequential, 001 branch, 01x jump, 10x jr
  localparam logic [2:0] PC_SEQ = 3'b000;
  localparam logic [2:0] PC_BR  = 3'b001;
  localparam logic [2:0] PC_J   = 3'b010;
  localparam logic [2:0] PC_JR  = 3'b100;

  // ID-stage operand mux selects
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Any non-sequential PCSrc redirects fetch and kills the instruction in IF
  function automatic logic pc_redirect(input logic [2:0] pcsrc);
    return pcsrc != PC_SEQ;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Single-operand forwarding comparator: picks regfile / EX / MEM source
// for one ID-stage operand and flags a load-use hazard on it.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic       uses,
  input  logic [4:0] ex_rd,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  output logic [1:0] sel,
  output logic       load_use
);

  logic ex_hit;
  logic mem_hit;

  // EX match wins over MEM; a load in EX cannot forward yet and stalls instead
  always_comb begin
    ex_hit   = uses && ex_regwrite && (ex_rd != '0) && (ex_rd == src);
    mem_hit  = uses && mem_regwrite && (mem_rd != '0) && (mem_rd == src);
    load_use = ex_hit && ex_memread;
    sel      = FWD_REG;
    if (ex_hit && !ex_memread) begin
      sel = FWD_EX;
    end else if (mem_hit) begin
      sel = FWD_MEM;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: ID operand
// forwarding, load-use and mul/div stalls, IF/ID flush on taken transfers.
// Optional perf counters enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_uses_rs,
  input  logic        ID_uses_rt,
  input  logic        ID_is_md,
  input  logic        ID_reads_hilo,
  input  logic [2:0]  PCSrc,
  input  logic [4:0]  EX_rd,
  input  logic [4:0]  MEM_rd,
  input  logic        EX_RegWrite,
  input  logic        MEM_RegWrite,
  input  logic        EX_MemRead,
  output logic [1:0]  FwdA,
  output logic [1:0]  FwdB,
  output logic        PC_Write,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Bubble,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam int CW = $clog2(MD_LATENCY + 1);

  logic [1:0]  sel_a;
  logic [1:0]  sel_b;
  logic        lu_a;
  logic        lu_b;
  logic        load_use;
  logic        md_stall;
  logic        stall;
  logic        redirect;
  state_t      state;
  state_t      state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  fwd_sel u_fwd_a (
    .src          (ID_rs),
    .uses         (ID_uses_rs),
    .ex_rd        (EX_rd),
    .ex_regwrite  (EX_RegWrite),
    .ex_memread   (EX_MemRead),
    .mem_rd       (MEM_rd),
    .mem_regwrite (MEM_RegWrite),
    .sel          (sel_a),
    .load_use     (lu_a)
  );

  fwd_sel u_fwd_b (
    .src          (ID_rt),
    .uses         (ID_uses_rt),
    .ex_rd        (EX_rd),
    .ex_regwrite  (EX_RegWrite),
    .ex_memread   (EX_MemRead),
    .mem_rd       (MEM_rd),
    .mem_regwrite (MEM_RegWrite),
    .sel          (sel_b),
    .load_use     (lu_b)
  );

  // Combine hazard sources; a stall suppresses any pending redirect
  always_comb begin
    load_use = lu_a || lu_b;
    md_stall = md_busy && (ID_is_md || ID_reads_hilo);
    stall    = load_use || md_stall;
    redirect = !stall && pc_redirect(PCSrc);
  end

  // FSM state and mul/div countdown register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state: accept an unstalled mul/div, then count down to 1
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_RUN: begin
        if (ID_is_md && !stall) begin
          state_next = ST_BUSY;
          cnt_next   = CW'(MD_LATENCY);
        end
      end
      ST_BUSY: begin
        if (cnt <= CW'(1)) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: begin
        state_next = ST_RUN;
        cnt_next   = '0;
      end
    endcase
  end

  // FSM outputs: busy for the whole countdown, done on its last cycle
  always_comb begin
    md_busy = (state == ST_BUSY);
    md_done = (state == ST_BUSY) && (cnt == CW'(1));
  end

  // Pipeline register controls; reset forces a held, bubbled pipeline
  always_comb begin
    FwdA        = sel_a;
    FwdB        = sel_b;
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    if (Rst) begin
      FwdA        = FWD_REG;
      FwdB        = FWD_REG;
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
    end else if (stall) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
    end else if (redirect) begin
      IFID_Flush = 1'b1;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  // Free-running perf counters, wrap modulo 2^32
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall) begin
        stall_q <= stall_q + 32'd1;
      end
      if (IFID_Flush) begin
        flush_q <= flush_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;
  import hazard_pkg::*;

  localparam int MDL = 8;
`ifdef PIPE_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int M_RUN   = 0;
  localparam int M_STALL = 1;
  localparam int M_FLUSH = 2;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [4:0]  ID_rs, ID_rt, EX_rd, MEM_rd;
  logic        ID_uses_rs, ID_uses_rt, ID_is_md, ID_reads_hilo;
  logic [2:0]  PCSrc;
  logic        EX_RegWrite, MEM_RegWrite, EX_MemRead;
  logic [1:0]  FwdA, FwdB;
  logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, md_busy, md_done;
  logic [31:0] stall_cycles, flush_count;

  pipe_hazard_ctrl #(.MD_LATENCY(MDL)) dut (
    .Clk(Clk), .Rst(Rst),
    .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
    .ID_is_md(ID_is_md), .ID_reads_hilo(ID_reads_hilo),
    .PCSrc(PCSrc),
    .EX_rd(EX_rd), .MEM_rd(MEM_rd),
    .EX_RegWrite(EX_RegWrite), .MEM_RegWrite(MEM_RegWrite),
    .EX_MemRead(EX_MemRead),
    .FwdA(FwdA), .FwdB(FwdB),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write),
    .IFID_Flush(IFID_Flush), .IDEX_Bubble(IDEX_Bubble),
    .md_busy(md_busy), .md_done(md_done),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       nm;
    logic [9:0]  ctl;
    bit          chk;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic push(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                      input int mode, input logic busy, input logic done,
                      input bit chk, input logic [31:0] sc, input logic [31:0] fc);
    exp_t e;
    logic [3:0] pipe;
    case (mode)
      M_STALL: pipe = 4'b0001;
      M_FLUSH: pipe = 4'b1110;
      default: pipe = 4'b1100;
    endcase
    e.nm  = nm;
    e.ctl = {fa, fb, pipe, busy, done};
    e.chk = chk;
    e.sc  = PERF ? sc : 32'd0;
    e.fc  = PERF ? fc : 32'd0;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    ID_rs = '0; ID_rt = '0; ID_uses_rs = 0; ID_uses_rt = 0;
    ID_is_md = 0; ID_reads_hilo = 0; PCSrc = PC_SEQ;
    EX_rd = '0; MEM_rd = '0; EX_RegWrite = 0; MEM_RegWrite = 0; EX_MemRead = 0;
  endtask

  // Monitor: one expectation per cycle, compared away from the rising edge
  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [9:0] act;
      e   = q.pop_front();
      act = {FwdA, FwdB, PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, md_busy, md_done};
      checks++;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl{fa,fb,pcw,ifw,fl,bub,busy,done} got=%b exp=%b", e.nm, act, e.ctl);
      end
      if (e.chk) begin
        checks++;
        if (stall_cycles !== e.sc || flush_count !== e.fc) begin
          errors++;
          $display("FAIL %s_ctr got stall=%0d flush=%0d exp stall=%0d flush=%0d",
                   e.nm, stall_cycles, flush_count, e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    Rst = 1'b1;
    tick();

    // Reset: outputs forced even with a live forwarding match and redirect
    ID_rs = 5; ID_uses_rs = 1; EX_rd = 5; EX_RegWrite = 1; PCSrc = PC_BR;
    push("reset", FWD_REG, FWD_REG, M_STALL, 0, 0, 1, 0, 0);
    tick();
    Rst = 1'b0;

    clr(); ID_rs = 5; ID_uses_rs = 1; EX_rd = 5; EX_RegWrite = 1; MEM_rd = 5; MEM_RegWrite = 1;
    push("fwd_ex_prio", FWD_EX, FWD_REG, M_RUN, 0, 0, 0, 0, 0);
    tick();

    EX_rd = 0;
    push("fwd_mem_rd0", FWD_MEM, FWD_REG, M_RUN, 0, 0, 0, 0, 0);
    tick();

    clr(); ID_rs = 5; ID_uses_rs = 1; ID_rt = 7; ID_uses_rt = 1; EX_rd = 7; MEM_rd = 7; MEM_RegWrite = 1;
    push("fwd_b_mem", FWD_REG, FWD_MEM, M_RUN, 0, 0, 0, 0, 0);
    tick();

    clr(); EX_MemRead = 1; EX_RegWrite = 1; EX_rd = 8; ID_rt = 8; ID_uses_rt = 1;
    push("load_use", FWD_REG, FWD_REG, M_STALL, 0, 0, 0, 0, 0);
    tick();

    clr(); ID_rt = 8; ID_uses_rt = 1; MEM_rd = 8; MEM_RegWrite = 1;
    push("load_fwd", FWD_REG, FWD_MEM, M_RUN, 0, 0, 0, 0, 0);
    tick();

    clr(); EX_MemRead = 1; EX_RegWrite = 1; EX_rd = 9; ID_rs = 9; ID_uses_rs = 1; PCSrc = PC_BR;
    push("lu_beats_br", FWD_REG, FWD_REG, M_STALL, 0, 0, 0, 0, 0);
    tick();

    clr(); ID_rs = 9; ID_uses_rs = 1; MEM_rd = 9; MEM_RegWrite = 1; PCSrc = PC_BR;
    push("br_flush", FWD_MEM, FWD_REG, M_FLUSH, 0, 0, 0, 0, 0);
    tick();

    clr(); PCSrc = PC_J;
    push("j_flush", FWD_REG, FWD_REG, M_FLUSH, 0, 0, 0, 0, 0);
    tick();

    PCSrc = PC_JR | 3'b001;
    push("jr_flush", FWD_REG, FWD_REG, M_FLUSH, 0, 0, 0, 0, 0);
    tick();

    clr();
    push("ctr1", FWD_REG, FWD_REG, M_RUN, 0, 0, 1, 2, 3);
    tick();

    // mul/div accepted, mflo waits through the whole busy window
    ID_is_md = 1;
    push("md_accept", FWD_REG, FWD_REG, M_RUN, 0, 0, 0, 0, 0);
    tick();
    ID_is_md = 0; ID_reads_hilo = 1;
    for (int i = 1; i <= MDL; i++) begin
      push((i == MDL) ? "md_done" : "md_busy", FWD_REG, FWD_REG, M_STALL, 1, (i == MDL), 0, 0, 0);
      tick();
    end
    push("mflo_go", FWD_REG, FWD_REG, M_RUN, 0, 0, 0, 0, 0);
    tick();
    clr();
    push("ctr2", FWD_REG, FWD_REG, M_RUN, 0, 0, 1, 10, 3);
    tick();

    // Reset landing mid-BUSY clears the unit immediately
    ID_is_md = 1;
    push("md_accept2", FWD_REG, FWD_REG, M_RUN, 0, 0, 0, 0, 0);
    tick();
    ID_is_md = 0;
    for (int i = 1; i <= 3; i++) begin
      push("md_busy2", FWD_REG, FWD_REG, M_RUN, 1, 0, 0, 0, 0);
      tick();
    end
    Rst = 1'b1;
    push("rst_mid_busy", FWD_REG, FWD_REG, M_STALL, 0, 0, 1, 0, 0);
    tick();
    Rst = 1'b0;
    push("post_rst", FWD_REG, FWD_REG, M_RUN, 0, 0, 0, 0, 0);
    tick();

    // Full-length busy after reset; a second md waits and then re-enters
    ID_is_md = 1;
    push("md_accept3", FWD_REG, FWD_REG, M_RUN, 0, 0, 0, 0, 0);
    tick();
    ID_is_md = 0;
    for (int i = 1; i < MDL; i++) begin
      push("md_busy3", FWD_REG, FWD_REG, M_RUN, 1, 0, 0, 0, 0);
      tick();
    end
    ID_is_md = 1;
    push("md_done3_stall", FWD_REG, FWD_REG, M_STALL, 1, 1, 0, 0, 0);
    tick();
    push("md_reaccept", FWD_REG, FWD_REG, M_RUN, 0, 0, 0, 0, 0);
    tick();
    ID_is_md = 0;
    push("md_busy4", FWD_REG, FWD_REG, M_RUN, 1, 0, 1, 1, 0);
    tick();

    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge Clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. Generates the 2-bit forwarding selects for the ID-stage operand muxes (regfile / EX result / MEM result) and stalls on load-use and multi-cycle multiply/divide hazards. Flushes IF/ID on taken control transfers decoded in ID. Sits beside the ID stage and drives the PC, IF/ID and ID/EX pipeline-register enables.

## Interface
Parameters:
- MD_LATENCY, 8, cycles a mul/div occupies the HI/LO unit (legal range 2..32).

Ports:
- Clk  in  1  pipeline clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- ID_rs, ID_rt  in  5  source register numbers of the instruction in ID
- ID_uses_rs, ID_uses_rt  in  1  instruction in ID actually reads rs / rt
- ID_is_md  in  1  instruction in ID is mult/multu/div/divu
- ID_reads_hilo  in  1  instruction in ID is mfhi/mflo
- PCSrc  in  3  next-PC select from ID decode: 000 seq, 001 taken branch, 01x jump, 10x jr
- EX_rd, MEM_rd  in  5  destination registers in EX and MEM
- EX_RegWrite, MEM_RegWrite  in  1  write-enable of those instructions
- EX_MemRead  in  1  instruction in EX is a load
- FwdA, FwdB  out  2  operand selects: 00 regfile, 01 EX result, 10 MEM result
- PC_Write, IFID_Write  out  1  register enables (0 = hold)
- IFID_Flush  out  1  load a nop into IF/ID
- IDEX_Bubble  out  1  load a nop into ID/EX
- md_busy, md_done  out  1  mul/div in progress; final busy cycle
- stall_cycles, flush_count  out  32  perf counters (PIPE_HAZARD_PERF_EN only)

## Operation
- Forwarding, per operand (rs→FwdA, rt→FwdB): 01 if uses && EX_RegWrite && EX_rd!=0 && EX_rd==src && !EX_MemRead; else 10 if uses && MEM_RegWrite && MEM_rd!=0 && MEM_rd==src; else 00. EX match takes priority over MEM. Code 11 never produced.
- Load-use stall: uses && EX_MemRead && EX_RegWrite && EX_rd!=0 && EX_rd==src, for either operand.
- MD stall: md_busy && (ID_is_md || ID_reads_hilo).
- stall = load-use stall | MD stall. On stall: PC_Write=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0; PCSrc ignored.
- Flush: !stall && PCSrc!=000 → IFID_Flush=1; PC_Write=IFID_Write=1.
- FSM, two states:
  - RUN: md_busy=0. ID_is_md && !stall → load cnt=MD_LATENCY, go BUSY.
  - BUSY: md_busy=1; cnt decrements each cycle; md_done=1 when cnt==1, then next state RUN.
- Counter width $clog2(MD_LATENCY+1); cnt never wraps below 1 in BUSY.

## Timing
- Forward selects, stall and flush are combinational from same-cycle inputs (zero latency); FSM and counters update on rising Clk.
- MD accepted in cycle t: md_busy high t+1..t+MD_LATENCY; md_done high in t+MD_LATENCY only; a stalled mfhi/mflo/md in ID proceeds in t+MD_LATENCY+1.
- Load-use stall lasts exactly one cycle, since the load advances to MEM and the operand becomes forwardable via 10.
- Simultaneous load-use stall and taken PCSrc: stall wins, no flush; the branch re-evaluates next cycle.
- Rst asserted (any time, including mid-BUSY): state RUN, cnt=0, md_busy=md_done=0, counters=0 immediately. While Rst is high: PC_Write=IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0, FwdA=FwdB=00.

## Configuration
- PIPE_HAZARD_PERF_EN defined: stall_cycles increments on every cycle with stall=1; flush_count increments on every cycle with IFID_Flush=1. Both wrap modulo 2^32 and clear on Rst.
- Not defined: both ports remain and are tied to 0; no counter flops are synthesized.

## Structure
- Shared package hazard_pkg: PCSrc encodings (PC_SEQ, PC_BR, PC_J, PC_JR), forward codes FWD_REG=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10, and the FSM state type (ST_RUN, ST_BUSY).
- Sub-module fwd_sel: one operand's comparator. It outputs a 2-bit select and a load-use flag, and is instantiated twice (rs, rt).

## Test plan
- EX_rd=5, EX_RegWrite=1, ID_rs=5, ID_uses_rs=1, MEM_rd=5, MEM_RegWrite=1 → FwdA=01 (EX priority); with EX_rd=0 instead → FwdA=10.
- EX_MemRead=1, EX_rd=8, ID_rt=8, ID_uses_rt=1 → one cycle PC_Write=0, IDEX_Bubble=1. Next cycle, with MEM_rd=8 → FwdB=10, no stall.
- MD_LATENCY=8, ID_is_md in cycle 0, mflo in ID from cycle 1 → md_busy cycles 1–8, md_done cycle 8, stall cycles 1–8, mflo advances cycle 9.
- PCSrc=001 together with a load-use hazard → IFID_Flush=0 that cycle. Next cycle, with no hazard → IFID_Flush=1 for one cycle.
- Rst pulsed in cycle 4 of BUSY → md_busy=0 immediately. A new ID_is_md after reset re-enters BUSY for a full MD_LATENCY.
- With PIPE_HAZARD_PERF_EN: 3 stall cycles and 2 flushes → stall_cycles=3, flush_count=2. Without the macro → both read 0.
